ball_mover: RTL

Per-frame motion engine for up to CNT balls. It produces the packed `xs`/`ys`/`balls` buses that the ball renderer consumes, so this block is the source side of that position interface. Once per frame tick it advances every active ball by its velocity and bounces it off the side walls, the top wall and the paddle. It retires balls that fall past the bottom edge and accepts launch requests for new balls.

---
 rtl/ball_mover.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ball_mover.sv
// ---------------------------------------------------------------------------
// ball_mover
//   Per-frame motion engine for CNT ball slots. On each frame tick it sweeps
//   the slots one per cycle, advancing every active ball by its velocity,
//   bouncing it off the side walls, the top wall and the paddle, and retiring
//   balls that drop past the bottom edge. In IDLE it also accepts launch
//   requests into the lowest free slot.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   frame       one-cycle frame tick; starts a sweep when IDLE
//   size        ball radius (sampled per slot during the sweep)
//   speed       launch speed magnitude
//   paddle_x    paddle centre x      (sampled per slot during the sweep)
//   paddle_hw   paddle half-width    (sampled per slot during the sweep)
//   launch      launch request, held until launch_ack
//   launch_x/y  spawn position
//   xs, ys      packed ball centres, slot i at bits [i*10+:10]
//   balls       slot-active mask
//   busy        sweep in progress (UPDATE or DONE)
//   done        one-cycle pulse in the final sweep cycle
//   lost        one-cycle pulse per retired ball, cycle after its update
//   launch_ack  one-cycle pulse, launch request consumed (taken or dropped)
//   full        all slots active
//   state_dbg   current FSM state, for checkers
//
// Handshake: launch/launch_ack is a request/acknowledge pair. The requester
// holds launch high until it sees launch_ack; the cycle in which launch_ack
// is high is never taken as a new request, so the requester may drop launch
// in that cycle or later.
// ---------------------------------------------------------------------------
module ball_mover #(
  parameter int CNT      = 3,
  parameter int XMAX     = 640,
  parameter int YMAX     = 480,
  parameter int PADDLE_Y = 440
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame,
  input  logic [5:0]        size,
  input  logic [3:0]        speed,
  input  logic [9:0]        paddle_x,
  input  logic [6:0]        paddle_hw,
  input  logic              launch,
  input  logic [9:0]        launch_x,
  input  logic [9:0]        launch_y,
  output logic [CNT*10-1:0] xs,
  output logic [CNT*10-1:0] ys,
  output logic [CNT-1:0]    balls,
  output logic              busy,
  output logic              done,
  output logic              lost,
  output logic              launch_ack,
  output logic              full,
  output logic [1:0]        state_dbg
);

  localparam int KW = (CNT > 1) ? $clog2(CNT) : 1;

  localparam logic signed [11:0] X_HI = 12'(XMAX - 1);
  localparam logic signed [11:0] Y_HI = 12'(YMAX - 1);
  localparam logic signed [11:0] PY   = 12'(PADDLE_Y);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            lost_q, lost_d;
  logic            ack_q, ack_d;

  logic [9:0]        x_q  [CNT];
  logic [9:0]        y_q  [CNT];
  logic signed [4:0] vx_q [CNT];
  logic signed [4:0] vy_q [CNT];
  logic [CNT-1:0]    balls_q;

  // Control from the FSM to the slot datapath
  logic            slot_upd;
  logic            launch_wr;
  logic            free_found;
  logic [KW-1:0]   free_idx;

  // Slot datapath, all signed 12-bit
  logic signed [11:0] x_s, y_s, vx_s, vy_s, sz_s, px_s, hw_s;
  logic signed [11:0] nx, ny, dx, adx;
  logic signed [4:0]  nvx, nvy;
  logic               paddle_hit;
  logic               floor_hit;

  // ---------------------------------------------------------------------
  // Lowest-index inactive slot for launches
  // ---------------------------------------------------------------------
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < CNT; i++) begin
      if (!balls_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = KW'(i);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Motion and collision for the slot selected by k_q
  // ---------------------------------------------------------------------
  always_comb begin
    x_s  = {2'b00, x_q[k_q]};
    y_s  = {2'b00, y_q[k_q]};
    vx_s = {{7{vx_q[k_q][4]}}, vx_q[k_q]};
    vy_s = {{7{vy_q[k_q][4]}}, vy_q[k_q]};
    sz_s = {6'd0, size};
    px_s = {2'b00, paddle_x};
    hw_s = {5'd0, paddle_hw};

    nx  = x_s + vx_s;
    ny  = y_s + vy_s;
    nvx = vx_q[k_q];
    nvy = vy_q[k_q];

    if (nx < sz_s) begin
      nx  = sz_s;
      nvx = -vx_q[k_q];
    end else if (nx > X_HI - sz_s) begin
      nx  = X_HI - sz_s;
      nvx = -vx_q[k_q];
    end

    if (ny < sz_s) begin
      ny  = sz_s;
      nvy = -vy_q[k_q];
    end

    dx  = nx - px_s;
    adx = dx[11] ? -dx : dx;

    // Paddle catches only a ball moving down that crosses the paddle
    // surface during this step, using the pre-move y for the "above" test.
    paddle_hit = (vy_s > 12'sd0) && (y_s + sz_s < PY) &&
                 (ny + sz_s >= PY) && (adx <= hw_s);

    floor_hit = 1'b0;
    if (paddle_hit) begin
      ny  = PY - sz_s;
      nvy = -vy_q[k_q];
    end else if (ny > Y_HI) begin
      floor_hit = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      lost_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      lost_q  <= lost_d;
      ack_q   <= ack_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and control
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    ack_d     = 1'b0;
    lost_d    = 1'b0;
    slot_upd  = 1'b0;
    launch_wr = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame) begin
          state_d = S_UPDATE;
          k_d     = '0;
        end else if (launch && !ack_q) begin
          // ack_q high means this is the cycle the requester is still
          // seeing the acknowledge for the previous request.
          ack_d     = 1'b1;
          launch_wr = free_found;
        end
      end
      S_UPDATE: begin
        slot_upd = balls_q[k_q];
        lost_d   = balls_q[k_q] && floor_hit;
        if (k_q == KW'(CNT - 1)) begin
          state_d = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Slot storage
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      balls_q <= '0;
      for (int i = 0; i < CNT; i++) begin
        x_q[i]  <= '0;
        y_q[i]  <= '0;
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
    end else begin
      if (launch_wr) begin
        x_q[free_idx]     <= launch_x;
        y_q[free_idx]     <= launch_y;
        vx_q[free_idx]    <= {1'b0, speed};
        vy_q[free_idx]    <= 5'd0 - {1'b0, speed};
        balls_q[free_idx] <= 1'b1;
      end
      if (slot_upd) begin
        if (floor_hit) begin
          // Retired ball keeps its last position on the bus.
          balls_q[k_q] <= 1'b0;
        end else begin
          x_q[k_q]  <= nx[9:0];
          y_q[k_q]  <= ny[9:0];
          vx_q[k_q] <= nvx;
          vy_q[k_q] <= nvy;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < CNT; g++) begin : g_out
    assign xs[g*10 +: 10] = x_q[g];
    assign ys[g*10 +: 10] = y_q[g];
  end

  assign balls      = balls_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign lost       = lost_q;
  assign launch_ack = ack_q;
  assign full       = &balls_q;
  assign state_dbg  = state_q;

endmodule
